// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states,
// divide iteration count and an operand magnitude helper.
package mdu_pkg;

  localparam int DIV_ITERS = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring divide iteration on a {remainder, quotient}
// shift register; returns the next partial remainder and the new quotient bit.
module div_step (
  input  logic [63:0] rem_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] top;

  // Shifted partial remainder can reach 33 bits before the trial subtract.
  assign top      = rem_in[63:31];
  assign q_bit    = (top >= {1'b0, divisor});
  assign rem_next = q_bit ? (top[31:0] - divisor) : top[31:0];

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit producing the HI/LO write stream; stalls the
// pipeline while computing and holds the result until the pipeline commits it.
//
// state | meaning
// IDLE  | waiting for Start
// MUL   | registering the 64-bit product
// DIV   | one restoring step per cycle, counter DIV_ITERS-1 down to 0
// DONE  | HI/LO write presented until Ready
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int DIV_ITERS = mdu_pkg::DIV_ITERS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        Cancel,
  input  logic        Ready,
  output logic        Busy,
  output logic        WriteHiEnable,
  output logic        WriteLoEnable,
  output logic [31:0] HiIn,
  output logic [31:0] LoIn
);

  state_t             state, state_nx, start_target;
  logic               accept, op_signed, op_div;
  logic [4:0]         count;
  logic signed [32:0] ma, mb;
  logic signed [63:0] prod;
  logic [63:0]        rem;
  logic [31:0]        divisor, hi, lo, step_rem, quo_fin;
  logic               step_q, neg_q, neg_r;

  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
  assign accept    = Start && !Cancel &&
                     ((state == ST_IDLE) || ((state == ST_DONE) && Ready));

  always_comb begin
    start_target = ST_MUL;
    if (op_div) start_target = (OperandB == 32'd0) ? ST_DONE : ST_DIV;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = start_target;
      ST_MUL:  state_nx = ST_DONE;
      ST_DIV:  if (count == 5'd0) state_nx = ST_DONE;
      ST_DONE: if (Ready) state_nx = accept ? start_target : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (Cancel) state_nx = ST_IDLE;
  end

  always_comb begin
    Busy          = 1'b0;
    WriteHiEnable = 1'b0;
    case (state)
      ST_MUL, ST_DIV: Busy = 1'b1;
      ST_DONE:        WriteHiEnable = !Cancel;
      default:        ;
    endcase
    WriteLoEnable = WriteHiEnable;
  end

  div_step u_div_step (
    .rem_in   (rem),
    .divisor  (divisor),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign prod    = 64'(ma) * 64'(mb);
  assign quo_fin = {rem[30:0], step_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ma      <= '0;
      mb      <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      ma      <= {op_signed & OperandA[31], OperandA};
      mb      <= {op_signed & OperandB[31], OperandB};
      rem     <= {32'd0, magnitude(OperandA, op_signed)};
      divisor <= magnitude(OperandB, op_signed);
      neg_q   <= op_signed & (OperandA[31] ^ OperandB[31]);
      neg_r   <= op_signed & OperandA[31];
      count   <= 5'(DIV_ITERS - 1);
      // Divide by zero skips the iterations and reports all-ones / dividend.
      if (op_div && (OperandB == 32'd0)) begin
        hi <= OperandA;
        lo <= 32'hFFFF_FFFF;
      end
    end else if (state == ST_MUL) begin
      {hi, lo} <= prod;
    end else if (state == ST_DIV) begin
      rem   <= {step_rem, quo_fin};
      count <= count - 5'd1;
      if (count == 5'd0) begin
        hi <= neg_r ? (~step_rem + 32'd1) : step_rem;
        lo <= neg_q ? (~quo_fin + 32'd1) : quo_fin;
      end
    end
  end

  assign HiIn = hi;
  assign LoIn = lo;

endmodule
